// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM latch, multi-cycle data-memory request/ack port,
// store lane steering, load extraction and a registered MEM/WB bundle.
// Upstream is stalled while an access is outstanding. An access that waits
// too long for its acknowledge is aborted.
module mem_access_stage #(
  parameter int TIMEOUT = 16  // cycles dmem_req_o may stay high without ack (2..255)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        reg_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        exc_misalign_o,
  output logic        exc_timeout_o
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // EX/MEM latch
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu;
  logic [31:0] ex_store_data;

  // FSM
  state_t      state;
  state_t      state_n;
  logic [7:0]  cnt;
  logic [7:0]  cnt_n;
  logic        req;
  logic        stall;
  logic        done;
  logic        timeout_hit;

  // Decode of the latched instruction
  logic        ex_mem_op;
  logic        ex_is_store;
  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic [1:0]  byte_off;
  logic        misaligned;
  logic        access_ok;

  // Datapath
  logic [3:0]  be_steer;
  logic [31:0] wdata_steer;
  logic [31:0] rdata_shift;
  logic [31:0] load_value;

  // Capture the EX results whenever the stage is not stalled; frozen otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid      <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_funct3     <= '0;
      ex_rd         <= '0;
      ex_alu        <= '0;
      ex_store_data <= '0;
    end else if (!stall) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge value of its sources, independent of statement order.
      ex_valid      <= valid_i;
      ex_mem_read   <= mem_read_i;
      ex_mem_write  <= mem_write_i;
      ex_reg_write  <= reg_write_i;
      ex_funct3     <= funct3_i;
      ex_rd         <= rd_i;
      ex_alu        <= alu_result_i;
      ex_store_data <= store_data_i;
    end
  end

  // A set write flag wins over a read flag; funct3 11x/x11 sizes decode as word.
  assign ex_mem_op   = ex_mem_read | ex_mem_write;
  assign ex_is_store = ex_mem_write;
  assign size_byte   = (ex_funct3[1:0] == 2'b00);
  assign size_half   = (ex_funct3[1:0] == 2'b01);
  assign size_word   = ~size_byte & ~size_half;
  assign byte_off    = ex_alu[1:0];
  assign misaligned  = (size_half & byte_off[0]) | (size_word & (byte_off != 2'b00));
  assign access_ok   = ex_valid & ex_mem_op & ~misaligned;

  // Store data replication and byte-enable generation from size and offset.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    wdata_steer = ex_store_data;
    be_steer    = 4'b1111;
    if (size_byte) begin
      wdata_steer = {4{ex_store_data[7:0]}};
      be_steer    = 4'b0001 << byte_off;
    end else if (size_half) begin
      wdata_steer = {2{ex_store_data[15:0]}};
      be_steer    = 4'b0011 << byte_off;
    end
  end

  // Select the addressed byte/half of the read word and extend it.
  always_comb begin
    rdata_shift = dmem_rdata_i >> {byte_off, 3'b000};
    load_value  = dmem_rdata_i;
    if (size_byte) begin
      load_value = {{24{~ex_funct3[2] & rdata_shift[7]}}, rdata_shift[7:0]};
    end else if (size_half) begin
      load_value = {{16{~ex_funct3[2] & rdata_shift[15]}}, rdata_shift[15:0]};
    end
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, request and stall decode. The counter holds the number of
  // cycles the request has already been high before the current one.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req         = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (access_ok) begin
          req = 1'b1;
          if (dmem_ack_i) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_n = S_ACCESS;
            cnt_n   = 8'd1;
          end
        end
      end
      S_ACCESS: begin
        req = 1'b1;
        if (dmem_ack_i) begin
          done    = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_n     = S_IDLE;
          cnt_n       = '0;
        end else begin
          stall = 1'b1;
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Memory port is combinational from the frozen latch, so it is stable for
  // the whole access and falls immediately when reset clears the latch.
  assign stall_o      = stall;
  assign dmem_req_o   = req;
  assign dmem_we_o    = req & ex_is_store;
  assign dmem_addr_o  = req ? {ex_alu[31:2], 2'b00} : 32'd0;
  assign dmem_wdata_o = (req & ex_is_store) ? wdata_steer : 32'd0;
  assign dmem_be_o    = req ? be_steer : 4'd0;

  // MEM/WB bundle: the latched instruction retires on any unstalled cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      exc_misalign_o <= 1'b0;
      exc_timeout_o  <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      exc_misalign_o <= 1'b0;
      exc_timeout_o  <= 1'b0;
      if (!stall && ex_valid) begin
        if (!ex_mem_op) begin
          wb_valid_o     <= 1'b1;
          wb_reg_write_o <= ex_reg_write;
          wb_rd_o        <= ex_rd;
          wb_data_o      <= ex_alu;
        end else if (misaligned) begin
          exc_misalign_o <= 1'b1;
        end else if (done) begin
          wb_valid_o     <= 1'b1;
          wb_reg_write_o <= ex_reg_write & ~ex_is_store;
          wb_rd_o        <= ex_rd;
          wb_data_o      <= ex_is_store ? ex_alu : load_value;
        end else if (timeout_hit) begin
          exc_timeout_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios from the
// stage's behaviour plus randomized instructions against a behavioural model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, mem_read_i, mem_write_i, reg_write_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_reg_write_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_misalign_o, exc_timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .reg_write_i(reg_write_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .exc_misalign_o(exc_misalign_o), .exc_timeout_o(exc_timeout_o)
  );

  task automatic drive_bubble();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0;
    funct3_i = 3'd0; rd_i = 5'd0; alu_result_i = 32'd0; store_data_i = 32'd0;
  endtask

  // Random upstream fields; they must be ignored while the stage stalls.
  task automatic drive_garbage();
    valid_i = 1'($urandom); mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
    reg_write_i = 1'($urandom); funct3_i = 3'($urandom); rd_i = 5'($urandom);
    alu_result_i = $urandom; store_data_i = $urandom;
  endtask

  // Present one instruction, play the memory side with the given ack latency
  // (cycles after the first request cycle; >= TIMEOUT means never), and check
  // the port every cycle plus the WB bundle afterwards. Entered and left in
  // the low clock phase.
  task automatic run_instr(input string tag, input logic v, input logic rd_en,
                           input logic wr_en, input logic rw, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] sd, input int ack_lat,
                           input logic [31:0] rdata);
    int          sz, off, k;
    bit          is_mem, store, aligned, go, acked, ack, to_cycle, exp_stall;
    bit          exp_wbv, exp_rw;
    logic [31:0] exp_addr, exp_wdata, exp_data, lv;
    logic [3:0]  exp_be;

    // Behavioural model of the instruction's effect.
    sz       = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off      = int'(alu[1:0]);
    is_mem   = v && (rd_en || wr_en);
    store    = wr_en;
    aligned  = (off % sz) == 0;
    go       = is_mem && aligned;
    acked    = go && (ack_lat < TIMEOUT);
    exp_addr = alu & 32'hFFFF_FFFC;
    exp_be   = 4'(((1 << sz) - 1) << off);
    if (sz == 1)      exp_wdata = (sd & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) exp_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
    else              exp_wdata = sd;
    if (sz == 4) lv = rdata;
    else begin
      lv = (rdata >> (8 * off)) & ((32'd1 << (8 * sz)) - 32'd1);
      if (!f3[2] && lv >= (32'd1 << (8 * sz - 1))) lv = lv - (32'd1 << (8 * sz));
    end
    exp_wbv  = v && (!(rd_en || wr_en) || acked);
    exp_rw   = exp_wbv && rw && !(is_mem && store);
    exp_data = is_mem ? lv : alu;

    valid_i = v; mem_read_i = rd_en; mem_write_i = wr_en; reg_write_i = rw;
    funct3_i = f3; rd_i = rd; alu_result_i = alu; store_data_i = sd;
    @(posedge clk);

    k = 0;
    while (1) begin
      @(negedge clk);
      ack        = go && (k == ack_lat);
      to_cycle   = go && !ack && (k == TIMEOUT - 1);
      exp_stall  = go && !ack && !to_cycle;
      dmem_ack_i = ack;
      dmem_rdata_i = ack ? rdata : $urandom;
      if (exp_stall) drive_garbage(); else drive_bubble();
      #1;
      checks++;
      if (dmem_req_o !== go) begin
        errors++; $display("FAIL %s req k=%0d got %b want %b", tag, k, dmem_req_o, go);
      end
      checks++;
      if (stall_o !== exp_stall) begin
        errors++; $display("FAIL %s stall k=%0d got %b want %b", tag, k, stall_o, exp_stall);
      end
      if (go) begin
        checks++;
        if (dmem_addr_o !== exp_addr) begin
          errors++; $display("FAIL %s addr k=%0d got %h want %h", tag, k, dmem_addr_o, exp_addr);
        end
        checks++;
        if (dmem_we_o !== store) begin
          errors++; $display("FAIL %s we k=%0d got %b want %b", tag, k, dmem_we_o, store);
        end
        if (store) begin
          checks++;
          if (dmem_be_o !== exp_be) begin
            errors++; $display("FAIL %s be k=%0d got %b want %b", tag, k, dmem_be_o, exp_be);
          end
          checks++;
          if (dmem_wdata_o !== exp_wdata) begin
            errors++; $display("FAIL %s wdata k=%0d got %h want %h", tag, k, dmem_wdata_o, exp_wdata);
          end
        end
      end
      if (!exp_stall) break;
      k++;
    end

    @(negedge clk);
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if (wb_valid_o !== exp_wbv) begin
      errors++; $display("FAIL %s wb_valid got %b want %b", tag, wb_valid_o, exp_wbv);
    end
    checks++;
    if (wb_reg_write_o !== exp_rw) begin
      errors++; $display("FAIL %s wb_reg_write got %b want %b", tag, wb_reg_write_o, exp_rw);
    end
    if (exp_wbv) begin
      checks++;
      if (wb_rd_o !== rd) begin
        errors++; $display("FAIL %s wb_rd got %0d want %0d", tag, wb_rd_o, rd);
      end
      if (!(is_mem && store)) begin
        checks++;
        if (wb_data_o !== exp_data) begin
          errors++; $display("FAIL %s wb_data got %h want %h", tag, wb_data_o, exp_data);
        end
      end
    end
    checks++;
    if (exc_misalign_o !== (is_mem && !aligned)) begin
      errors++; $display("FAIL %s exc_misalign got %b want %b", tag, exc_misalign_o, is_mem && !aligned);
    end
    checks++;
    if (exc_timeout_o !== (go && !acked)) begin
      errors++; $display("FAIL %s exc_timeout got %b want %b", tag, exc_timeout_o, go && !acked);
    end
    checks++;
    if (dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL %s req_after got %b want 0", tag, dmem_req_o);
    end

    // Pulses last exactly one cycle; the bubble behind retires invisibly.
    @(negedge clk);
    #1;
    checks++;
    if ({wb_valid_o, exc_misalign_o, exc_timeout_o} !== 3'b000) begin
      errors++; $display("FAIL %s pulse_clear got %b want 000", tag,
                         {wb_valid_o, exc_misalign_o, exc_timeout_o});
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    drive_bubble();
    #12;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_be_o, wb_valid_o, wb_reg_write_o,
         exc_misalign_o, exc_timeout_o} !== 11'd0) begin
      errors++; $display("FAIL reset ctrl got %b want 0", {stall_o, dmem_req_o, dmem_we_o,
                         dmem_be_o, wb_valid_o, wb_reg_write_o, exc_misalign_o, exc_timeout_o});
    end
    checks++;
    if ({dmem_addr_o, dmem_wdata_o, wb_data_o, wb_rd_o} !== 101'd0) begin
      errors++; $display("FAIL reset data got addr=%h wdata=%h wb=%h rd=%0d want 0",
                         dmem_addr_o, dmem_wdata_o, wb_data_o, wb_rd_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_alu_pass();
    run_instr("alu_rd5", 1, 0, 0, 1, 3'd0, 5'd5, 32'h1234, 32'hDEAD_BEEF, 0, 32'd0);
    run_instr("alu_norw", 1, 0, 0, 0, 3'd2, 5'd17, 32'hCAFE_F00D, 32'd0, 0, 32'd0);
    run_instr("bubble_memflags", 0, 1, 1, 1, 3'd2, 5'd3, 32'h40, 32'd1, 0, 32'd0);
  endtask

  task automatic test_load_ext();
    run_instr("lb_103", 1, 1, 0, 1, 3'b000, 5'd9, 32'h103, 32'd0, 2, 32'h80FF_0000);
    run_instr("lbu_103", 1, 1, 0, 1, 3'b100, 5'd9, 32'h103, 32'd0, 2, 32'h80FF_0000);
    run_instr("lh_102", 1, 1, 0, 1, 3'b001, 5'd10, 32'h102, 32'd0, 1, 32'h9ABC_1234);
    run_instr("lhu_102", 1, 1, 0, 1, 3'b101, 5'd11, 32'h102, 32'd0, 0, 32'h9ABC_1234);
    run_instr("lw_ill", 1, 1, 0, 1, 3'b111, 5'd12, 32'h204, 32'd0, TIMEOUT - 1, 32'h1357_9BDF);
  endtask

  task automatic test_store_steer();
    run_instr("sh_102", 1, 0, 1, 1, 3'b001, 5'd4, 32'h102, 32'hABCD_5678, 0, 32'd0);
    run_instr("sb_101", 1, 0, 1, 0, 3'b000, 5'd4, 32'h101, 32'h0000_00A5, 3, 32'd0);
    run_instr("rw_both", 1, 1, 1, 1, 3'b010, 5'd6, 32'h300, 32'h0BAD_F00D, 1, 32'hFFFF_FFFF);
  endtask

  task automatic test_misalign();
    run_instr("lw_102", 1, 1, 0, 1, 3'b010, 5'd8, 32'h102, 32'd0, 0, 32'd0);
    run_instr("sh_odd", 1, 0, 1, 0, 3'b001, 5'd8, 32'h3, 32'h1111, 0, 32'd0);
  endtask

  task automatic test_timeout();
    run_instr("lw_200_to", 1, 1, 0, 1, 3'b010, 5'd13, 32'h200, 32'd0, 1000, 32'd0);
    run_instr("after_to", 1, 0, 0, 1, 3'd0, 5'd14, 32'h55AA_55AA, 32'd0, 0, 32'd0);
  endtask

  // Consecutive ALU ops, one per cycle: each appears on WB two edges later.
  task automatic test_back_to_back();
    localparam int N = 12;
    logic        ev[N];
    logic        erw[N];
    logic [4:0]  erd[N];
    logic [31:0] ealu[N];
    for (int i = 0; i < N + 2; i++) begin
      if (i >= 2) begin
        checks++;
        if (wb_valid_o !== ev[i-2] || (ev[i-2] && (wb_reg_write_o !== erw[i-2] ||
            wb_rd_o !== erd[i-2] || wb_data_o !== ealu[i-2]))) begin
          errors++; $display("FAIL b2b[%0d] got v=%b rw=%b rd=%0d d=%h want v=%b rw=%b rd=%0d d=%h",
                             i - 2, wb_valid_o, wb_reg_write_o, wb_rd_o, wb_data_o,
                             ev[i-2], erw[i-2], erd[i-2], ealu[i-2]);
        end
      end
      checks++;
      if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        errors++; $display("FAIL b2b stall/req cycle %0d got %b%b want 00", i, stall_o, dmem_req_o);
      end
      if (i < N) begin
        ev[i] = ($urandom_range(0, 3) != 0); erw[i] = 1'($urandom);
        erd[i] = 5'($urandom); ealu[i] = $urandom;
        drive_bubble();
        valid_i = ev[i]; reg_write_i = erw[i]; rd_i = erd[i]; alu_result_i = ealu[i];
        funct3_i = 3'($urandom); store_data_i = $urandom;
      end else begin
        drive_bubble();
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [2:0] f3_set[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    for (int i = 0; i < 80; i++) begin
      int   kind, lat;
      logic v, rdn, wrn;
      kind = $urandom_range(0, 3);
      v    = ($urandom_range(0, 7) != 0);
      rdn  = (kind == 1) || (kind == 3);
      wrn  = (kind == 2) || (kind == 3);
      lat  = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2)
                                         : $urandom_range(0, 4);
      run_instr($sformatf("rnd%0d", i), v, rdn, wrn, 1'($urandom),
                f3_set[$urandom_range(0, 6)], 5'($urandom), $urandom, $urandom,
                lat, $urandom);
    end
  endtask

  task automatic test_reset_mid_access();
    drive_bubble();
    valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; funct3_i = 3'b010;
    rd_i = 5'd7; alu_result_i = 32'h40;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_garbage();
      dmem_ack_i = 1'b0;
      #1;
      checks++;
      if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin
        errors++; $display("FAIL rst_mid wait%0d got req=%b stall=%b want 1 1", c, dmem_req_o, stall_o);
      end
    end
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, stall_o, wb_valid_o, exc_timeout_o} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid async got req=%b stall=%b wbv=%b to=%b want 0000",
                         dmem_req_o, stall_o, wb_valid_o, exc_timeout_o);
    end
    @(negedge clk);
    drive_bubble();
    rst_i = 1'b1;
    #1;
    @(negedge clk);
    #1;
    checks++;
    if ({dmem_req_o, stall_o, wb_valid_o} !== 3'b000) begin
      errors++; $display("FAIL rst_mid after got req=%b stall=%b wbv=%b want 000",
                         dmem_req_o, stall_o, wb_valid_o);
    end
    run_instr("post_rst", 1, 1, 0, 1, 3'b010, 5'd7, 32'h40, 32'd0, 1, 32'h0123_4567);
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_load_ext();
    test_store_steer();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
